// File: rtl/if_stage_mq.sv
// Multi-outstanding instruction-fetch stage: PC generator, pending-PC FIFO and
// an instruction queue to decode. Redirects flush at once; stale responses are counted off.
module if_stage_mq #(
    parameter int                MAX_OUTSTANDING = 2,
    parameter int                FETCH_Q         = 4,
    parameter int                ADDR_W          = 32,
    parameter int                INST_W          = 32,
    parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(32'h1c000000)
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             redirect_valid,
    input  logic [ADDR_W-1:0]                redirect_pc,
    output logic                             inst_valid,
    output logic [ADDR_W-1:0]                inst_addr,
    input  logic                             inst_addr_ok,
    input  logic                             inst_data_ok,
    input  logic [INST_W-1:0]                inst_rdata,
    input  logic                             inst_excp,
    output logic                             fs_to_ds_valid,
    output logic [ADDR_W-1:0]                fs_pc,
    output logic [INST_W-1:0]                fs_inst,
    output logic                             fs_excp,
    output logic                             fs_adef,
    input  logic                             ds_allowin,
    output logic [$clog2(FETCH_Q):0]         fq_count,
    output logic [$clog2(MAX_OUTSTANDING):0] inflight
);
    localparam int QW = $clog2(FETCH_Q);
    localparam int CW = QW + 1;
    localparam int IW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = CW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              excp;
        logic              adef;
    } fq_ent_t;

    logic [ADDR_W-1:0] r_pc;
    logic [IW-1:0]     r_inflight;
    logic [IW-1:0]     r_drop;
    logic              r_halted;
    logic [ADDR_W-1:0] r_pend [MAX_OUTSTANDING];
    logic [PW-1:0]     r_pwr, r_prd;
    fq_ent_t           r_q [FETCH_Q];
    logic [QW-1:0]     r_qwr, r_qrd;
    logic [CW-1:0]     r_count;

    logic    w_credit, w_req, w_enq_rsp, w_adef, w_enq, w_deq;
    fq_ent_t w_ent;

    function automatic logic [PW-1:0] pnext(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit term reserves a queue slot for every response still on the bus.
    assign w_credit = (SW'(r_inflight) + SW'(r_count)) < SW'(FETCH_Q);
    assign inst_valid = resetn && !redirect_valid && !r_halted && (r_pc[1:0] == 2'b00)
                      && (r_inflight < IW'(MAX_OUTSTANDING)) && w_credit;
    assign inst_addr  = r_pc;
    assign w_req      = inst_valid && inst_addr_ok;

    assign w_enq_rsp = inst_data_ok && !redirect_valid && (r_drop == '0);
    // ADEF waits until every live response is home so it lands in program order.
    assign w_adef    = resetn && !redirect_valid && !r_halted && (r_pc[1:0] != 2'b00)
                     && (r_inflight == r_drop) && (r_count < CW'(FETCH_Q));
    assign w_enq     = w_enq_rsp || w_adef;

    assign fs_to_ds_valid = resetn && !redirect_valid && (r_count != '0);
    assign w_deq          = fs_to_ds_valid && ds_allowin;
    assign fs_pc          = r_q[r_qrd].pc;
    assign fs_inst        = r_q[r_qrd].inst;
    assign fs_excp        = r_q[r_qrd].excp;
    assign fs_adef        = r_q[r_qrd].adef;
    assign fq_count       = r_count;
    assign inflight       = r_inflight;

    always_comb begin
        w_ent      = '0;
        w_ent.pc   = w_adef ? r_pc : r_pend[r_prd];
        w_ent.excp = w_adef || inst_excp;
        w_ent.adef = w_adef;
        if (!w_adef && !inst_excp) w_ent.inst = inst_rdata;
    end

    always_ff @(posedge clk) begin
        if (w_req) r_pend[r_pwr] <= r_pc;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
            r_halted   <= 1'b0;
            r_pwr      <= '0;
            r_prd      <= '0;
            r_qwr      <= '0;
            r_qrd      <= '0;
            r_count    <= '0;
            for (int i = 0; i < FETCH_Q; i++) r_q[i] <= '0;
        end else begin
            r_inflight <= r_inflight + IW'(w_req) - IW'(inst_data_ok);
            if (w_req)        r_pwr <= pnext(r_pwr);
            if (inst_data_ok) r_prd <= pnext(r_prd);
            if (redirect_valid) begin
                r_pc     <= redirect_pc;
                r_halted <= 1'b0;
                r_drop   <= r_inflight - IW'(inst_data_ok);
                r_qwr    <= '0;
                r_qrd    <= '0;
                r_count  <= '0;
            end else begin
                if (w_req) r_pc <= r_pc + ADDR_W'(4);
                if (inst_data_ok && (r_drop != '0)) r_drop <= r_drop - IW'(1);
                if ((w_enq_rsp && inst_excp) || w_adef) r_halted <= 1'b1;
                if (w_enq) begin
                    r_q[r_qwr] <= w_ent;
                    r_qwr      <= r_qwr + QW'(1);
                end
                if (w_deq) r_qrd <= r_qrd + QW'(1);
                r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            end
        end
    end

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!resetn)
        inst_data_ok |-> (r_inflight != '0));
endmodule
